// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with per-key debounce and press events
module keypad_scan #(
  parameter int CLK_FREQ  = 12000000,
  parameter int SCAN_HZ   = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_any
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       CNT_LAST = 4'(DEB_SCANS - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [3:0]       cnt [16];

  logic             tick;
  logic [3:0]       pressed;
  logic [15:0]      state_nxt;
  logic [3:0]       cnt_nxt [16];
  logic [3:0]       rise;
  logic [3:0]       k;
  logic [1:0]       first_row;

  assign tick    = (div == DIV_LAST);
  assign pressed = ~sync2;

  // Debounce update for the four keys of the active column, evaluated only on the tick
  always_comb begin
    state_nxt = key_state;
    cnt_nxt   = cnt;
    rise      = '0;
    k         = '0;
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        k = {col, 2'(r)};
        if (pressed[r] == key_state[k]) begin
          cnt_nxt[k] = '0;
        end else if (cnt[k] == CNT_LAST) begin
          state_nxt[k] = pressed[r];
          cnt_nxt[k]   = '0;
          rise[r]      = pressed[r];
        end else begin
          cnt_nxt[k] = cnt[k] + 4'd1;
        end
      end
    end
  end

  // Lowest newly pressed row wins the event when several rise together
  always_comb begin
    first_row = 2'd3;
    if (rise[0])      first_row = 2'd0;
    else if (rise[1]) first_row = 2'd1;
    else if (rise[2]) first_row = 2'd2;
  end

  // Synchronizer, scan divider, column walk, debounce state and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      div       <= '0;
      col       <= 2'd0;
      col_n     <= 4'b1110;
      key_state <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_any   <= 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      sync1 <= row_n;
      sync2 <= sync1;
      if (tick) begin
        div   <= '0;
        col   <= col + 2'd1;
        col_n <= ~(4'b0001 << (col + 2'd1));
      end else begin
        div <= div + 1'b1;
      end
      key_state <= state_nxt;
      key_any   <= |state_nxt;
      cnt       <= cnt_nxt;
      key_valid <= |rise;
      if (|rise) key_code <= {col, first_row};
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
module tb_keypad_scan;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_any;

  logic [15:0] pressed = '0;
  int          errors = 0;
  int          checks = 0;
  int          ev_count = 0;
  logic [3:0]  last_code = '0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [15:0] exp_state;
    int          exp_events;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs [9];

  always #5 clk_in = ~clk_in;

  keypad_scan #(.CLK_FREQ(1000), .SCAN_HZ(100), .DEB_SCANS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .row_n(row_n), .col_n(col_n),
    .key_state(key_state), .key_valid(key_valid), .key_code(key_code), .key_any(key_any)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_n = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] col_mask(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  // Event monitor on the falling edge: counts pulses and checks they last one cycle
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (key_valid) begin
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        ev_count++;
        last_code = key_code;
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Present one sample of a key during the next window of column c
  task automatic sample_window(input int c, input logic v, input int key);
    int n1;
    int n2;
    n1 = 0;
    n2 = 0;
    while (col_n != col_mask(c) && n1 < 100) begin step(); n1++; end
    pressed[key] = v;
    while (col_n == col_mask(c) && n2 < 100) begin step(); n2++; end
    check("window_timeout", {31'd0, (n1 < 100 && n2 < 100)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"}, {28'd0, col_n}, 32'he);
    check({tag, "_key_state"}, {16'd0, key_state}, 32'd0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_key_code"}, {28'd0, key_code}, 32'd0);
    check({tag, "_key_any"}, {31'd0, key_any}, 32'd0);
  endtask

  initial begin
    int ev0;
    vecs[0] = '{16'h0000, 16'h0000, 0, 4'd0};
    vecs[1] = '{16'h0200, 16'h0200, 1, 4'd9};
    vecs[2] = '{16'h0200, 16'h0200, 0, 4'd9};
    vecs[3] = '{16'h0000, 16'h0000, 0, 4'd9};
    vecs[4] = '{16'h5000, 16'h5000, 1, 4'd12};
    vecs[5] = '{16'h0000, 16'h0000, 0, 4'd12};
    vecs[6] = '{16'h0008, 16'h0008, 1, 4'd3};
    vecs[7] = '{16'h00C8, 16'h00C8, 1, 4'd6};
    vecs[8] = '{16'h0000, 16'h0000, 0, 4'd6};

    repeat (3) step();
    check_reset_outputs("reset");

    // Column walk from reset release: each column held exactly 10 cycles
    rst_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check($sformatf("col_walk_%0d", i), {28'd0, col_n}, {28'd0, col_mask((i / 10) % 4)});
      check("idle_no_valid", {31'd0, key_valid}, 32'd0);
      step();
    end

    // Table of held-key patterns, each applied for 5 full scan rounds
    for (int v = 0; v < 9; v++) begin
      ev0 = ev_count;
      pressed = vecs[v].keys;
      repeat (200) step();
      check($sformatf("vec%0d_state", v), {16'd0, key_state}, {16'd0, vecs[v].exp_state});
      check($sformatf("vec%0d_any", v), {31'd0, key_any}, {31'd0, |vecs[v].exp_state});
      check($sformatf("vec%0d_events", v), ev_count - ev0, vecs[v].exp_events);
      check($sformatf("vec%0d_code", v), {28'd0, last_code}, {28'd0, vecs[v].exp_code});
    end

    // Bounce on key 5: alternating samples never reach the threshold
    ev0 = ev_count;
    for (int i = 0; i < 6; i++) sample_window(1, (i % 2) == 0, 5);
    repeat (3) step();
    check("bounce_state", {31'd0, key_state[5]}, 32'd0);
    check("bounce_events", ev_count - ev0, 0);
    for (int i = 0; i < 3; i++) sample_window(1, 1'b1, 5);
    check("bounce_3_stable", {31'd0, key_state[5]}, 32'd0);
    sample_window(1, 1'b1, 5);
    check("bounce_4_stable", {31'd0, key_state[5]}, 32'd1);
    repeat (3) step();
    check("bounce_one_event", ev_count - ev0, 1);
    check("bounce_code", {28'd0, last_code}, 32'd5);
    pressed = '0;
    repeat (200) step();
    check("bounce_release", {16'd0, key_state}, 32'd0);

    // Reset while a key is held, then re-debounce the same key
    pressed = 16'h0200;
    repeat (200) step();
    check("pre_reset_state", {16'd0, key_state}, 32'h0200);
    repeat (13) step();
    rst_in = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) step();
    rst_in = 1'b0;
    ev0 = ev_count;
    check("post_reset_col", {28'd0, col_n}, 32'he);
    repeat (200) step();
    check("rereport_state", {16'd0, key_state}, 32'h0200);
    check("rereport_events", ev_count - ev0, 1);
    check("rereport_code", {28'd0, last_code}, 32'd9);
    check("rereport_any", {31'd0, key_any}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
